// File: rtl/valid_ready_accum.sv
// Purpose: reduces each group of up to MAX_N upstream beats (sum/max/min) to one downstream result.
// Latency: result valid one cycle after the clk edge that accepts the group's closing beat.
// Backpressure: ready_a = ~valid_b | ready_b, so a held result stalls every upstream beat; full throughput otherwise.
module valid_ready_accum #(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 4,
    parameter int LEN_W  = $clog2(MAX_N + 1),
    parameter int OUT_W  = DATA_W + $clog2(MAX_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_a,
    input  logic              last_a,
    output logic              ready_a,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [1:0]        cfg_mode,
    output logic [OUT_W-1:0]  data_out,
    output logic [LEN_W-1:0]  cnt_out,
    output logic              valid_b,
    input  logic              ready_b
);

    localparam logic [LEN_W-1:0] MAX_N_L   = LEN_W'(MAX_N);
    localparam logic [1:0]       MODE_MAX  = 2'd1;
    localparam logic [1:0]       MODE_MIN  = 2'd2;

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       mode_q, mode_d;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic [LEN_W-1:0] cout_q, cout_d;
    logic             vb_q, vb_d;

    logic             acc_a;
    logic             xfer_b;
    logic             close;
    logic [LEN_W-1:0] len_clamp;
    logic [LEN_W-1:0] len_e;
    logic [1:0]       mode_e;
    logic [LEN_W-1:0] cnt_inc;
    logic [OUT_W-1:0] data_ext;
    logic [OUT_W-1:0] combine;

    assign ready_a  = ~vb_q | ready_b;
    assign acc_a    = valid_a & ready_a;
    assign xfer_b   = vb_q & ready_b;

    assign valid_b  = vb_q;
    assign data_out = dout_q;
    assign cnt_out  = cout_q;

    // Effective group config: live inputs on the first beat, latched copy for the rest of the group.
    always_comb begin
        len_clamp = ((cfg_len == '0) || (cfg_len > MAX_N_L)) ? MAX_N_L : cfg_len;
        len_e     = (cnt_q == '0) ? len_clamp : len_q;
        mode_e    = (cnt_q == '0) ? cfg_mode : mode_q;
        cnt_inc   = cnt_q + 1'b1;
        close     = acc_a & ((cnt_inc == len_e) | last_a);
    end

    // Reduction of the running value with the incoming beat; first beat seeds the accumulator.
    always_comb begin
        data_ext = OUT_W'(data_in);
        combine  = acc_q + data_ext;
        if (cnt_q == '0) begin
            combine = data_ext;
        end else if (mode_e == MODE_MAX) begin
            combine = (acc_q > data_ext) ? acc_q : data_ext;
        end else if (mode_e == MODE_MIN) begin
            combine = (acc_q < data_ext) ? acc_q : data_ext;
        end
    end

    // Next-state for group tracking and the output holding register.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        mode_d = mode_q;
        dout_d = dout_q;
        cout_d = cout_q;
        vb_d   = vb_q;
        if (acc_a && (cnt_q == '0)) begin
            len_d  = len_clamp;
            mode_d = cfg_mode;
        end
        if (close) begin
            dout_d = combine;
            cout_d = cnt_inc;
            cnt_d  = '0;
            vb_d   = 1'b1;
        end else begin
            if (acc_a) begin
                acc_d = combine;
                cnt_d = cnt_inc;
            end
            if (xfer_b) begin
                vb_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset; a reset drops any partial group.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            mode_q <= '0;
            dout_q <= '0;
            cout_q <= '0;
            vb_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            mode_q <= mode_d;
            dout_q <= dout_d;
            cout_q <= cout_d;
            vb_q   <= vb_d;
        end
    end

endmodule

// File: tb/tb_valid_ready_accum.sv
// Purpose: directed checks of valid_ready_accum with hand-computed expected results.
// Latency: inputs driven and outputs sampled on the falling edge, one cycle per beat.
// Backpressure: ready_b is driven directly to exercise stall, release and close-with-transfer.
module tb_valid_ready_accum;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       valid_a;
    logic       last_a;
    logic       ready_a;
    logic [2:0] cfg_len;
    logic [1:0] cfg_mode;
    logic [9:0] data_out;
    logic [2:0] cnt_out;
    logic       valid_b;
    logic       ready_b;

    int checks_cnt;
    int fail_cnt;

    valid_ready_accum dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .valid_a  (valid_a),
        .last_a   (last_a),
        .ready_a  (ready_a),
        .cfg_len  (cfg_len),
        .cfg_mode (cfg_mode),
        .data_out (data_out),
        .cnt_out  (cnt_out),
        .valid_b  (valid_b),
        .ready_b  (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one beat for one clock edge, then idles the upstream port.
    task automatic send(input logic [7:0] d, input logic l);
        data_in = d;
        last_a  = l;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        last_a  = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [9:0] d, input logic [2:0] c);
        chk({tag, "_vb"},  32'(valid_b),  32'd1);
        chk({tag, "_dat"}, 32'(data_out), 32'(d));
        chk({tag, "_cnt"}, 32'(cnt_out),  32'(c));
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n      = 1'b0;
        data_in    = '0;
        valid_a    = 1'b0;
        last_a     = 1'b0;
        cfg_len    = 3'd4;
        cfg_mode   = 2'd0;
        ready_b    = 1'b1;
        tick();
        tick();
        chk("rst_vb",  32'(valid_b),  32'd0);
        chk("rst_dat", 32'(data_out), 32'd0);
        chk("rst_cnt", 32'(cnt_out),  32'd0);
        rst_n = 1'b1;
        chk("rst_rdy", 32'(ready_a), 32'd1);

        // Basic sum group of four.
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        chk("sum_early_vb", 32'(valid_b), 32'd0);
        send(8'd4, 1'b0);
        chk_res("sum4", 10'd10, 3'd4);
        tick();
        chk("sum4_pulse", 32'(valid_b), 32'd0);

        // Width limit, then max and min modes.
        for (int i = 0; i < 4; i++) send(8'd255, 1'b0);
        chk_res("sum255", 10'd1020, 3'd4);
        cfg_mode = 2'd1;
        send(8'd3, 1'b0);
        send(8'd9, 1'b0);
        send(8'd2, 1'b0);
        send(8'd7, 1'b0);
        chk_res("max", 10'd9, 3'd4);
        cfg_mode = 2'd2;
        send(8'd3, 1'b0);
        send(8'd9, 1'b0);
        send(8'd2, 1'b0);
        send(8'd7, 1'b0);
        chk_res("min", 10'd2, 3'd4);

        // Early close via last_a, then single-beat groups back to back.
        cfg_mode = 2'd0;
        send(8'd5, 1'b0);
        send(8'd6, 1'b1);
        chk_res("last", 10'd11, 3'd2);
        cfg_len = 3'd1;
        send(8'd8, 1'b0);
        chk_res("len1a", 10'd8, 3'd1);
        send(8'd9, 1'b0);
        chk_res("len1b", 10'd9, 3'd1);
        tick();
        chk("len1_drop", 32'(valid_b), 32'd0);

        // Backpressure: result held, upstream stalled with a non-closing beat presented.
        cfg_len = 3'd4;
        ready_b = 1'b0;
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        send(8'd4, 1'b0);
        chk_res("bp", 10'd10, 3'd4);
        data_in = 8'd7;
        valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rdy",  32'(ready_a),  32'd0);
            chk("bp_hold", 32'(data_out), 32'd10);
            chk("bp_vb",   32'(valid_b),  32'd1);
        end
        valid_a = 1'b0;
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        chk("bp_rel_vb",  32'(valid_b), 32'd0);
        chk("bp_rel_rdy", 32'(ready_a), 32'd1);

        // Backpressure with a closing beat waiting at release.
        cfg_len = 3'd2;
        send(8'd4, 1'b0);
        send(8'd5, 1'b0);
        chk_res("bp2", 10'd9, 3'd2);
        cfg_len = 3'd1;
        data_in = 8'd20;
        valid_a = 1'b1;
        tick();
        tick();
        chk("bp2_rdy",  32'(ready_a),  32'd0);
        chk("bp2_hold", 32'(data_out), 32'd9);
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        valid_a = 1'b0;
        chk_res("bp2_new", 10'd20, 3'd1);
        ready_b = 1'b1;
        tick();
        chk("bp2_drop", 32'(valid_b), 32'd0);

        // cfg_len=0 means MAX_N; mid-group cfg_len change is ignored.
        cfg_len = 3'd0;
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        send(8'd4, 1'b0);
        chk("len0_early", 32'(valid_b), 32'd0);
        send(8'd5, 1'b0);
        chk_res("len0", 10'd14, 3'd4);
        cfg_len = 3'd4;
        send(8'd1, 1'b0);
        cfg_len = 3'd2;
        send(8'd2, 1'b0);
        chk("cfgchg_2", 32'(valid_b), 32'd0);
        send(8'd3, 1'b0);
        chk("cfgchg_3", 32'(valid_b), 32'd0);
        send(8'd4, 1'b0);
        chk_res("cfgchg", 10'd10, 3'd4);

        // Reset mid-group discards the partial group.
        cfg_len = 3'd4;
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_vb",  32'(valid_b),  32'd0);
        chk("mrst_dat", 32'(data_out), 32'd0);
        chk("mrst_cnt", 32'(cnt_out),  32'd0);
        for (int i = 0; i < 4; i++) send(8'd3, 1'b0);
        chk_res("mrst_grp", 10'd12, 3'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/valid_ready_accum.md
# valid_ready_accum

Parametrised valid/ready group accumulator. It takes a stream of DATA_W-bit beats on an upstream valid/ready port and reduces each group of up to MAX_N beats to one result on a downstream valid/ready port. Group length and reduction mode (sum/max/min) are set at run time, and a group can be closed early with last_a. It sits between a producer and a consumer stage in the datapath.

## Interface
- DATA_W, 8: input beat width (unsigned).
- MAX_N, 4: maximum beats per group, ≥1.
- LEN_W, $clog2(MAX_N+1): width of cfg_len.
- OUT_W, DATA_W+$clog2(MAX_N): result width. With defaults this is 10, so the sum cannot overflow.
- clk  in  1  clock. Single clock domain.
- rst_n  in  1  reset. Synchronous, active-low.
- data_in  in  DATA_W  upstream beat.
- valid_a  in  1  upstream valid.
- last_a  in  1  closes the current group with this beat. Qualified by the handshake.
- ready_a  out  1  upstream ready.
- cfg_len  in  LEN_W  group length. 0 or >MAX_N means MAX_N.
- cfg_mode  in  2  0 sum, 1 max, 2 min, 3 reserved (treated as sum).
- data_out  out  OUT_W  group result.
- cnt_out  out  LEN_W  number of beats in the reported group.
- valid_b  out  1  downstream valid.
- ready_b  in  1  downstream ready.

## Operation
- Upstream accept: acc_a = valid_a & ready_a. Downstream transfer: xfer_b = valid_b & ready_b.
- ready_a = ~valid_b | ready_b (combinational). This gives full throughput: a new closing beat can be accepted in the same cycle the pending result is taken.
- Internal registers:
  - acc (OUT_W): running result.
  - cnt (LEN_W): beats accepted in the open group, 0 = idle/group start.
  - len_q, mode_q: configuration latched on the first beat of a group (cnt==0 & acc_a).
- cfg_len and cfg_mode changes mid-group are ignored until the next group.
- Effective length: len_e = (cnt==0) ? clamp(cfg_len) : len_q.
- Effective mode: mode_e = (cnt==0) ? cfg_mode : mode_q.
- Combine: first beat of a group yields zero-extended data_in. Later beats:
  - sum: acc+data_in
  - max: larger of acc and data_in (unsigned)
  - min: smaller of acc and data_in (unsigned)
  - Upper OUT_W-DATA_W bits are always 0 in max/min modes.
- close = acc_a & ((cnt+1 == len_e) | last_a).
- On acc_a & ~close: acc <= combine; cnt <= cnt+1.
- On close:
  - data_out <= combine; cnt_out <= cnt+1; valid_b <= 1.
  - cnt <= 0. acc is don't-care.
- valid_b next state:
  - close → 1
  - else xfer_b → 0
  - else hold.
- data_out and cnt_out change only on close. They are stable while valid_b=1 & ready_b=0.
- Each result is transferred exactly once. valid_b never stays high after a transfer unless a new group closed in that same cycle.
- last_a with valid_a=0, or while ready_a=0, has no effect.

## Timing
- Reset (rst_n=0 at a clk edge): valid_b=0, data_out=0, cnt_out=0, cnt=0, acc=0, len_q=0, mode_q=0. ready_a=1 in the first cycle after reset.
- Reset mid-group discards the partial group. The first beat after reset starts a new group.
- Latency: valid_b rises 1 cycle after the clk edge that accepts the closing beat.
- Throughput:
  - 1 beat/cycle upstream while ready_b=1.
  - With len=1, one result per cycle back-to-back.
- Backpressure: valid_b=1 & ready_b=0 forces ready_a=0. Upstream stalls, including non-closing beats.
- Simultaneous close and xfer_b in one cycle: the old result is consumed, the new result is loaded, and valid_b stays 1.
- cnt never exceeds len_e-1 between beats, so there is no wrap-around.
- last_a on the first beat produces a 1-beat group with cnt_out=1.

## Test plan
- Defaults, cfg_len=4, mode sum, ready_b=1, beats 1,2,3,4 on consecutive cycles → one cycle after the 4th accept: valid_b=1, data_out=10, cnt_out=4, valid_b high for exactly one cycle.
- Width limits: sum of 255,255,255,255 → 1020. Then mode max on 3,9,2,7 → 9. Then mode min on 3,9,2,7 → 2.
- cfg_len=4, beats 5,6 with last_a on 6 → data_out=11, cnt_out=2. The next beat 8 with cfg_len=1 → data_out=8, cnt_out=1.
- Backpressure:
  - Hold ready_b=0 after a result (data_out=10) → ready_a=0, data_out stable for 5 cycles.
  - Release ready_b for 1 cycle → result is transferred once and valid_b drops.
  - Repeat with a closing beat pending at release → valid_b stays 1 and data_out updates to the new group's result.
- cfg_len=0 → behaves as MAX_N=4. Changing cfg_len from 4 to 2 after beat 1 → the group still closes after 4 beats.
- Reset: assert rst_n=0 for one cycle after 2 beats (1,2) → all outputs 0. The following beats 3,3,3,3 → data_out=12, cnt_out=4.
